mdu_iter: RTL and testbench

- Parametrised iterative multiply/divide unit with integrated HI/LO result registers.
- Sits in the EX stage of the pipelined MIPS core and replaces the fixed 32-bit MDU.
- Runs MULT/MULTU/DIV/DIVU over WIDTH-bit operands using one shared WIDTH+1-bit adder/subtractor, one bit per cycle.
- Signals busy/ready so the hazard unit can hold EX; supports flush-abort and direct HI/LO writes (MTHI/MTLO).

---
 rtl/mdu_pkg.sv | 19 +
 rtl/mdu_iter.sv | 120 ++++++++++++
 tb/tb_mdu_iter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and HI/LO write-enable bit positions
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    localparam int HILO_HI = 1;
    localparam int HILO_LO = 0;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_CALC,
        MDU_FIX,
        MDU_DONE
    } mduState_t;

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative bit-serial multiply/divide unit with HI/LO result registers
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mduState_t state, nextState;
    logic [CW-1:0] cnt;
    // acc[2W:W] is the product high half or the W+1-bit remainder,
    // acc[W-1:0] the multiplier being consumed or the dividend/quotient
    logic [2*WIDTH:0] acc;
    logic [WIDTH-1:0] mb;
    logic isDiv, negRes, negRem;
    logic accept, isSigned, noBorrow;
    logic [WIDTH-1:0] absA, absB, quo, remd, fixHi, fixLo;
    logic [WIDTH:0] addA, addB, shifted;
    logic [WIDTH+1:0] sum;
    logic [2*WIDTH:0] accStep;
    logic [2*WIDTH-1:0] prodFix;

    assign accept   = start && !flush && (state == MDU_IDLE || state == MDU_DONE);
    assign isSigned = !op[0];
    assign absA     = (isSigned && a[WIDTH-1]) ? -a : a;
    assign absB     = (isSigned && b[WIDTH-1]) ? -b : b;

    // one shared W+1-bit adder: add for shift-add multiply, subtract (carry = no borrow) for division
    assign shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign addA     = isDiv ? shifted : acc[2*WIDTH:WIDTH];
    assign addB     = isDiv ? ~{1'b0, mb} : {1'b0, mb};
    assign sum      = {1'b0, addA} + {1'b0, addB} + {{(WIDTH+1){1'b0}}, isDiv};
    assign noBorrow = sum[WIDTH+1];
    assign accStep  = isDiv ? {noBorrow ? sum[WIDTH:0] : shifted, acc[WIDTH-2:0], noBorrow}
                    : acc[0] ? {1'b0, sum[WIDTH:0], acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH:1]};

    // sign correction applied while in FIX
    assign prodFix  = negRes ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    assign quo      = acc[WIDTH-1:0];
    assign remd     = acc[2*WIDTH-1:WIDTH];
    assign fixLo    = isDiv ? (negRes ? -quo : quo) : prodFix[WIDTH-1:0];
    assign fixHi    = isDiv ? (negRem ? -remd : remd) : prodFix[2*WIDTH-1:WIDTH];

    // next-state logic; flush overrides everything
    always_comb begin
        nextState = state;
        if (flush)
            nextState = MDU_IDLE;
        else if (accept)
            nextState = MDU_CALC;
        else if (state == MDU_CALC && cnt == LAST)
            nextState = MDU_FIX;
        else if (state == MDU_FIX)
            nextState = MDU_DONE;
        else if (state == MDU_DONE)
            nextState = MDU_IDLE;
    end

    // state, datapath and registered busy/ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= MDU_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mb     <= '0;
            isDiv  <= 1'b0;
            negRes <= 1'b0;
            negRem <= 1'b0;
            busy   <= 1'b0;
            ready  <= 1'b0;
        end else begin
            state <= nextState;
            busy  <= nextState == MDU_CALC || nextState == MDU_FIX;
            ready <= nextState == MDU_DONE;
            if (accept) begin
                acc    <= {{(WIDTH+1){1'b0}}, absA};
                mb     <= absB;
                isDiv  <= op[1];
                // a zero divisor keeps the all-ones quotient unnegated
                negRes <= isSigned && (a[WIDTH-1] ^ b[WIDTH-1]) && |b;
                negRem <= isSigned && a[WIDTH-1];
                cnt    <= '0;
            end else if (state == MDU_CALC) begin
                acc <= accStep;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // HI/LO: completion beats MTHI/MTLO on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (nextState == MDU_DONE) begin
            hi <= fixHi;
            lo <= fixLo;
        end else begin
            if (hilo_we[HILO_HI]) hi <= hilo_wdata;
            if (hilo_we[HILO_LO]) lo <= hilo_wdata;
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter (WIDTH=32 and WIDTH=8)
module tb_mdu_iter;
    import mdu_pkg::*;

    logic clk = 0, rst = 1;
    logic start = 0, flush = 0;
    logic [1:0] op = 0, hilo_we = 0;
    logic [31:0] a = 0, b = 0, hilo_wdata = 0;
    logic busy, ready;
    logic [31:0] hi, lo;

    logic start8 = 0, flush8 = 0;
    logic [1:0] op8 = 0, hiloWe8 = 0;
    logic [7:0] a8 = 0, b8 = 0, hiloWdata8 = 0;
    logic busy8, ready8;
    logic [7:0] hi8, lo8;

    int total = 0, passed = 0;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .hilo_we(hilo_we), .hilo_wdata(hilo_wdata), .busy(busy), .ready(ready), .hi(hi), .lo(lo)
    );

    mdu_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8), .flush(flush8),
        .hilo_we(hiloWe8), .hilo_wdata(hiloWdata8), .busy(busy8), .ready(ready8), .hi(hi8), .lo(lo8)
    );

    // reference: plain integer arithmetic on w-bit two's complement values
    function automatic void model(input int w, input logic [1:0] o, input longint unsigned x, y,
                                  output longint unsigned h, output longint unsigned l);
        longint unsigned mask, up;
        longint sx, sy, p, t;
        mask = (64'd1 << w) - 64'd1;
        sx = longint'(x);
        sy = longint'(y);
        if (x[w-1]) sx = sx - (longint'(1) << w);
        if (y[w-1]) sy = sy - (longint'(1) << w);
        h = 0;
        l = 0;
        if (o == MDU_MULT) begin
            p = sx * sy;
            t = p >>> w;
            h = longint'(t) & mask;
            l = longint'(p) & mask;
        end else if (o == MDU_MULTU) begin
            up = x * y;
            h = (up >> w) & mask;
            l = up & mask;
        end else if (y == 0) begin
            h = x;
            l = mask;
        end else if (o == MDU_DIV) begin
            t = sx / sy;
            p = sx % sy;
            l = t & mask;
            h = p & mask;
        end else begin
            l = x / y;
            h = x % y;
        end
    endfunction

    // launch one op on the 32-bit unit from the current cycle; returns latency (-1 on timeout)
    task automatic doOp32(input logic [1:0] o, input logic [31:0] x, y,
                          output logic [31:0] h, output logic [31:0] l, output int lat, output bit busyOk);
        busyOk = 1;
        lat = -1;
        start = 1; op = o; a = x; b = y;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            start = 0;
            if (busy !== (c <= 33)) busyOk = 0;
            if (ready === 1'b1) begin
                lat = c;
                break;
            end
        end
        h = hi;
        l = lo;
    endtask

    task automatic doOp8(input logic [1:0] o, input logic [7:0] x, y,
                         output logic [7:0] h, output logic [7:0] l, output int lat, output bit busyOk);
        busyOk = 1;
        lat = -1;
        start8 = 1; op8 = o; a8 = x; b8 = y;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            start8 = 0;
            if (busy8 !== (c <= 9)) busyOk = 0;
            if (ready8 === 1'b1) begin
                lat = c;
                break;
            end
        end
        h = hi8;
        l = lo8;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        total++; if ({busy, ready} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {busy, ready}); else passed++;
        total++; if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo: got %h want 0", {hi, lo}); else passed++;
        total++; if ({busy8, ready8, hi8, lo8} !== 18'h0) $display("FAIL reset_w8: got %h want 0", {busy8, ready8, hi8, lo8}); else passed++;
    endtask

    task automatic test_mult_signed();
        logic [31:0] h, l; int lat; bit bOk;
        doOp32(MDU_MULT, 32'hFFFFFFFE, 32'd3, h, l, lat, bOk);
        total++; if (lat != 34) $display("FAIL mult_latency: got %0d want 34", lat); else passed++;
        total++; if (!bOk) $display("FAIL mult_busy_profile: got bad want busy in cycles 1..33 only"); else passed++;
        total++; if (h !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h want FFFFFFFF", h); else passed++;
        total++; if (l !== 32'hFFFFFFFA) $display("FAIL mult_lo: got %h want FFFFFFFA", l); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] h, l; int lat; bit bOk;
        doOp32(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, h, l, lat, bOk);
        total++; if ({h, l} !== 64'hFFFFFFFE_00000001) $display("FAIL multu_max: got %h want FFFFFFFE00000001", {h, l}); else passed++;
        doOp32(MDU_DIV, 32'hFFFFFFF9, 32'd2, h, l, lat, bOk);
        total++; if (lat != 34) $display("FAIL b2b_latency: got %0d want 34", lat); else passed++;
        total++; if (l !== 32'hFFFFFFFD) $display("FAIL div_neg_quot: got %h want FFFFFFFD", l); else passed++;
        total++; if (h !== 32'hFFFFFFFF) $display("FAIL div_neg_rem: got %h want FFFFFFFF", h); else passed++;
    endtask

    task automatic test_div_edges();
        logic [31:0] h, l; int lat; bit bOk;
        doOp32(MDU_DIVU, 32'h12345678, 32'd0, h, l, lat, bOk);
        total++; if ({h, l} !== 64'h12345678_FFFFFFFF) $display("FAIL divu_zero: got %h want 12345678FFFFFFFF", {h, l}); else passed++;
        total++; if (lat != 34) $display("FAIL divzero_latency: got %0d want 34", lat); else passed++;
        doOp32(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, h, l, lat, bOk);
        total++; if ({h, l} !== 64'h00000000_80000000) $display("FAIL div_overflow: got %h want 0000000080000000", {h, l}); else passed++;
        doOp32(MDU_DIV, 32'hFFFFFFF0, 32'd0, h, l, lat, bOk);
        total++; if ({h, l} !== 64'hFFFFFFF0_FFFFFFFF) $display("FAIL div_zero_neg: got %h want FFFFFFF0FFFFFFFF", {h, l}); else passed++;
    endtask

    task automatic test_flush();
        logic [31:0] h, l, ml, mh, loBefore; int lat; bit bOk;
        longint unsigned eh, el;
        @(posedge clk); #1;
        hilo_we = 2'b10; hilo_wdata = 32'hAAAA5555;
        @(posedge clk); #1;
        hilo_we = 2'b00;
        loBefore = lo;
        total++; if (hi !== 32'hAAAA5555) $display("FAIL mthi: got %h want AAAA5555", hi); else passed++;
        start = 1; op = MDU_DIV; a = 32'd1000; b = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start = 0;
        end
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        total++; if ({busy, ready} !== 2'b00) $display("FAIL flush_abort: got busy/ready %b want 00", {busy, ready}); else passed++;
        total++; if ({hi, lo} !== {32'hAAAA5555, loBefore}) $display("FAIL flush_hilo: got %h want %h", {hi, lo}, {32'hAAAA5555, loBefore}); else passed++;
        doOp32(MDU_DIV, 32'hFFFFFC18, 32'd7, h, l, lat, bOk);
        model(32, MDU_DIV, 64'hFFFFFC18, 64'd7, eh, el);
        mh = eh[31:0]; ml = el[31:0];
        total++; if (lat != 34 || !bOk) $display("FAIL after_flush_start: got latency %0d busyOk %0d want 34 1", lat, bOk); else passed++;
        total++; if ({h, l} !== {mh, ml}) $display("FAIL after_flush_result: got %h want %h", {h, l}, {mh, ml}); else passed++;
    endtask

    task automatic test_start_flush_ignore();
        int lat;
        start = 1; flush = 1; op = MDU_MULT; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 0; flush = 0;
        total++; if (busy !== 1'b0) $display("FAIL start_with_flush: got busy %b want 0", busy); else passed++;
        @(posedge clk); #1;
        total++; if ({busy, ready} !== 2'b00) $display("FAIL start_with_flush_later: got %b want 00", {busy, ready}); else passed++;
        start = 1; op = MDU_MULTU; a = 32'd5; b = 32'd6;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            start = 0;
            if (c == 5) begin
                start = 1; op = MDU_DIVU; a = 32'd1000; b = 32'd3;
            end
            if (ready === 1'b1) begin
                lat = c;
                break;
            end
        end
        total++; if (lat != 34) $display("FAIL start_while_busy_latency: got %0d want 34", lat); else passed++;
        total++; if ({hi, lo} !== 64'd30) $display("FAIL start_while_busy_result: got %h want 30", {hi, lo}); else passed++;
    endtask

    task automatic test_hilo();
        @(posedge clk); #1;
        hilo_we = 2'b11; hilo_wdata = 32'h0F0F0F0F;
        @(posedge clk); #1;
        hilo_we = 2'b00;
        total++; if ({hi, lo} !== 64'h0F0F0F0F_0F0F0F0F) $display("FAIL hilo_both: got %h want 0F0F0F0F0F0F0F0F", {hi, lo}); else passed++;
        start = 1; op = MDU_DIVU; a = 32'd100; b = 32'd7;
        for (int c = 1; c <= 33; c++) begin
            @(posedge clk); #1;
            start = 0;
            if (c == 3) begin
                hilo_we = 2'b01; hilo_wdata = 32'h13572468;
            end else if (c == 4) begin
                hilo_we = 2'b00;
                total++; if ({hi, lo} !== 64'h0F0F0F0F_13572468) $display("FAIL mtlo_busy: got %h want 0F0F0F0F13572468", {hi, lo}); else passed++;
            end
        end
        hilo_we = 2'b11; hilo_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        hilo_we = 2'b00;
        total++; if (ready !== 1'b1) $display("FAIL collision_ready: got %b want 1", ready); else passed++;
        total++; if ({hi, lo} !== {32'd2, 32'd14}) $display("FAIL collision_result: got %h want 000000020000000E", {hi, lo}); else passed++;
    endtask

    task automatic test_reset_mid();
        start = 1; op = MDU_MULT; a = 32'd123; b = 32'd456;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            start = 0;
        end
        total++; if (busy !== 1'b1) $display("FAIL pre_reset_busy: got %b want 1", busy); else passed++;
        rst = 1;
        #1;
        total++; if ({busy, ready} !== 2'b00) $display("FAIL mid_reset_flags: got %b want 00", {busy, ready}); else passed++;
        total++; if ({hi, lo} !== 64'h0) $display("FAIL mid_reset_hilo: got %h want 0", {hi, lo}); else passed++;
        @(posedge clk); #1;
        rst = 0;
        repeat (36) begin
            @(posedge clk); #1;
            total++; if ({busy, ready} !== 2'b00) $display("FAIL post_reset_idle: got %b want 00", {busy, ready}); else passed++;
        end
    endtask

    task automatic test_width8();
        logic [7:0] h, l, mh, ml; int lat; bit bOk;
        longint unsigned eh, el;
        logic [1:0] o; logic [7:0] x, y;
        doOp8(MDU_MULT, 8'h80, 8'h80, h, l, lat, bOk);
        total++; if (lat != 10 || !bOk) $display("FAIL w8_latency: got %0d busyOk %0d want 10 1", lat, bOk); else passed++;
        total++; if ({h, l} !== 16'h4000) $display("FAIL w8_mult: got %h want 4000", {h, l}); else passed++;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = 8'($urandom);
            y = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            doOp8(o, x, y, h, l, lat, bOk);
            model(8, o, longint'(x), longint'(y), eh, el);
            mh = eh[7:0]; ml = el[7:0];
            total++; if ({h, l} !== {mh, ml} || lat != 10 || !bOk)
                $display("FAIL w8_random op=%0d a=%h b=%h: got %h lat %0d want %h lat 10", o, x, y, {h, l}, lat, {mh, ml});
            else passed++;
        end
    endtask

    task automatic test_random32();
        logic [31:0] h, l, mh, ml, x, y; int lat; bit bOk;
        longint unsigned eh, el;
        logic [1:0] o;
        logic [31:0] special [5];
        special = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 4) == 0) ? special[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 4) == 0) ? special[$urandom_range(0, 4)] : $urandom;
            if (i % 3 == 1) y = y >> $urandom_range(0, 31);
            doOp32(o, x, y, h, l, lat, bOk);
            model(32, o, longint'(x), longint'(y), eh, el);
            mh = eh[31:0]; ml = el[31:0];
            total++; if ({h, l} !== {mh, ml} || lat != 34 || !bOk)
                $display("FAIL random op=%0d a=%h b=%h: got %h lat %0d want %h lat 34", o, x, y, {h, l}, lat, {mh, ml});
            else passed++;
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_back_to_back();
        test_div_edges();
        test_flush();
        test_start_flush_ignore();
        test_hilo();
        test_reset_mid();
        test_width8();
        test_random32();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
